// File: rtl/tile_loader_pkg.sv
// tile_loader_pkg: shared element/row types, default widths and FSM states for the tile loader
package tile_loader_pkg;
  localparam int IL_DEF = 4;
  localparam int FL_DEF = 16;
  localparam int ROW_ELEMS = 16;
  typedef logic signed [IL_DEF+FL_DEF-1:0] elem_t;
  typedef elem_t [ROW_ELEMS-1:0] row_t;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
endpackage

// File: rtl/tile_loader_ctrl.sv
// tile_loader_ctrl: control FSM and row counter for the tile loader
// ports: clk/reset, start/mode_in request, in_valid/tile_ack handshakes in;
//        in_ready, mode, tile_valid, busy (all registered) and row_cnt out
module tile_loader_ctrl import tile_loader_pkg::*; #(
  parameter int lane = 512,
  localparam int CW = lane > 1 ? $clog2(lane) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_in,
  input  logic          in_valid,
  input  logic          tile_ack,
  output logic          in_ready,
  output logic          mode,
  output logic          tile_valid,
  output logic          busy,
  output logic [CW-1:0] row_cnt
);
  state_t state;
  logic [CW-1:0] last;
  always_comb last = mode ? CW'(lane - 1) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row_cnt <= '0;
      mode <= 1'b0;
      in_ready <= 1'b0;
      tile_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          mode <= mode_in;
          row_cnt <= '0;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        FILL: if (in_valid) begin
          if (row_cnt == last) begin
            state <= HOLD;
            in_ready <= 1'b0;
            tile_valid <= 1'b1;
          end else row_cnt <= row_cnt + 1'b1;
        end
        HOLD: if (tile_ack) begin
          state <= IDLE;
          tile_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/tile_loader.sv
// tile_loader: assembles a broadcast or per-lane tile of 16-element rows for the dataflow stage
// ports: start/mode_in request a tile, in_valid/in_ready/in_data stream rows,
//        out/mode present the tile, tile_valid/tile_ack hand it over, busy when not idle
module tile_loader import tile_loader_pkg::*; #(
  parameter int IL = IL_DEF,
  parameter int FL = FL_DEF,
  parameter int lane = 512,
  localparam int W = IL + FL,
  localparam int CW = lane > 1 ? $clog2(lane) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 mode_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [ROW_ELEMS-1:0][W-1:0]   in_data,
  output logic signed [lane-1:0][ROW_ELEMS-1:0][W-1:0] out,
  output logic                                 mode,
  output logic                                 tile_valid,
  input  logic                                 tile_ack,
  output logic                                 busy
);
  logic [CW-1:0] row_cnt;
  tile_loader_ctrl #(.lane(lane)) ctrl (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .in_valid(in_valid), .tile_ack(tile_ack), .in_ready(in_ready),
    .mode(mode), .tile_valid(tile_valid), .busy(busy), .row_cnt(row_cnt)
  );
  // busy low means the FSM is idle, so start here is an accepted request
  always_ff @(posedge clk) begin
    if (reset || (start && !busy)) out <= '0;
    else if (in_valid && in_ready) out[row_cnt] <= in_data;
  end
endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: randomized and directed check of tile_loader against a transaction-level model
module tb_tile_loader;
  logic clk = 1'b0;
  logic reset, start, mode_in, in_valid, tile_ack;
  logic in_ready, mode, tile_valid, busy;
  logic signed [15:0][19:0] in_data;
  logic signed [3:0][15:0][19:0] out;
  int tests = 0, fails = 0, ncyc = 0;
  // reference: phase 0 idle, 1 collecting rows, 2 holding a finished tile
  int m_ph = 0, m_cnt = 0;
  logic m_mode = 1'b0;
  logic [3:0][15:0][19:0] m_out = '0;

  tile_loader #(.IL(4), .FL(16), .lane(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out(out), .mode(mode), .tile_valid(tile_valid), .tile_ack(tile_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0][19:0] row_of(input logic [19:0] v);
    return {16{v}};
  endfunction

  function automatic logic [15:0][19:0] rnd_row();
    logic [15:0][19:0] r;
    for (int k = 0; k < 16; k++) r[k] = 20'($urandom);
    return r;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit mi, input bit v, input bit a,
                     input logic [15:0][19:0] d);
    reset = r; start = s; mode_in = mi; in_valid = v; tile_ack = a; in_data = d;
    @(posedge clk);
    if (r) begin
      m_ph = 0; m_cnt = 0; m_mode = 1'b0; m_out = '0;
    end else if (m_ph == 0) begin
      if (s) begin m_ph = 1; m_mode = mi; m_cnt = 0; m_out = '0; end
    end else if (m_ph == 1) begin
      if (v) begin
        m_out[m_cnt] = d;
        m_cnt++;
        if (m_cnt == (m_mode ? 4 : 1)) m_ph = 2;
      end
    end else if (a) m_ph = 0;
    ncyc++;
    #1;
    check("status", 320'({in_ready, tile_valid, busy, mode}),
          320'({m_ph == 1, m_ph == 2, m_ph != 0, m_mode}));
    for (int i = 0; i < 4; i++) check($sformatf("row%0d", i), out[i], m_out[i]);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rnd_row());
  endtask

  initial begin
    int t0;
    int pat[6] = '{1, 0, 0, 1, 1, 1};
    cyc(1, 1, 1, 1, 1, rnd_row());
    cyc(1, 0, 0, 0, 0, '0);
    // per-lane load with in_valid held high
    cyc(0, 1, 1, 0, 0, '0);
    t0 = ncyc;
    for (int k = 0; k < 20 && !tile_valid; k++) cyc(0, 0, 0, 1, 0, row_of(20'(k + 1)));
    check("lat_perlane", 320'(ncyc - t0 + 1), 320'(5));
    check("perlane_r3", out[3], row_of(20'h00004));
    cyc(0, 0, 0, 0, 1, '0);
    // broadcast of -1
    cyc(0, 1, 0, 0, 0, '0);
    t0 = ncyc;
    for (int k = 0; k < 20 && !tile_valid; k++) cyc(0, 0, 0, 1, 0, row_of(20'hFFFFF));
    check("lat_bcast", 320'(ncyc - t0 + 1), 320'(2));
    check("bcast_r0", out[0], row_of(20'hFFFFF));
    check("bcast_r1", out[1], '0);
    // back-pressure during a per-lane fill
    cyc(0, 0, 0, 0, 1, '0);
    cyc(0, 1, 1, 0, 0, '0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, pat[k] != 0, 0, row_of(20'(16 * k + 7)));
    check("bp_r1", out[1], row_of(20'(16 * 3 + 7)));
    // hold stability with start and beats pulsed, then release
    for (int k = 0; k < 10; k++) cyc(0, k % 2 == 0, ~mode, 1, 0, rnd_row());
    cyc(0, 0, 0, 0, 1, '0);
    idle_n(1);
    // reset after two accepted rows, then a fresh load
    cyc(0, 1, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, rnd_row());
    cyc(0, 0, 0, 1, 0, rnd_row());
    cyc(1, 0, 0, 1, 0, rnd_row());
    cyc(0, 1, 1, 0, 0, '0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0, rnd_row());
    // tile_ack together with start: start must be dropped
    cyc(0, 1, 0, 0, 1, '0);
    cyc(0, 0, 0, 0, 0, '0);
    check("ack_start_busy", 320'(busy), 320'(0));
    // random traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
          1'($urandom), $urandom_range(0, 3) == 0, rnd_row());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
